// File: rtl/ram_arb_nport.sv
// Shared single-port block RAM serving NUM_CH requesters with round-robin arbitration.
// Define RAM_ARB_CLEAR_EN to zero-fill the whole array after every reset release.
module ram_arb_nport #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              req_valid,
  output logic [NUM_CH-1:0]              req_ready,
  input  logic [NUM_CH-1:0]              req_we,
  input  logic [NUM_CH*BE_WIDTH-1:0]     req_be,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_CH-1:0]              rsp_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]   rsp_rdata,
  output logic                           busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]                  state_r;
  logic                        busy_r;
  logic [CH_W-1:0]             last_grant_r;
  logic [NUM_CH-1:0]           rsp_valid_r;
  logic [NUM_CH*DATA_WIDTH-1:0] rsp_rdata_r;
  logic [DATA_WIDTH-1:0]       mem_r [0:DEPTH-1];
`ifdef RAM_ARB_CLEAR_EN
  logic [ADDR_WIDTH-1:0]       clr_addr_r;
`endif

  logic                        run_s;
  logic [NUM_CH-1:0]           grant_s;
  logic [CH_W-1:0]             gidx_s;
  logic                        found_s;
  int                          arb_idx_s;
  logic                        xfer_s;
  logic                        sel_we_s;
  logic [BE_WIDTH-1:0]         sel_be_s;
  logic [ADDR_WIDTH-1:0]       sel_addr_s;
  logic [DATA_WIDTH-1:0]       sel_wdata_s;

  assign run_s     = (state_r == ST_RUN);
  assign xfer_s    = run_s & found_s;
  assign req_ready = run_s ? grant_s : {NUM_CH{1'b0}};
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign busy      = busy_r;

  // Round-robin search starting one past the last channel that transferred
  always_comb begin
    grant_s   = '0;
    gidx_s    = '0;
    found_s   = 1'b0;
    arb_idx_s = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      arb_idx_s = (int'(last_grant_r) + k) % NUM_CH;
      if (!found_s && req_valid[arb_idx_s]) begin
        grant_s[arb_idx_s] = 1'b1;
        gidx_s             = CH_W'(arb_idx_s);
        found_s            = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Route the granted channel's request fields to the memory port
  always_comb begin
    sel_we_s    = req_we[gidx_s];
    sel_be_s    = req_be[gidx_s*BE_WIDTH +: BE_WIDTH];
    sel_addr_s  = req_addr[gidx_s*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata_s = req_wdata[gidx_s*DATA_WIDTH +: DATA_WIDTH];
  end

  // Control state, busy flag and clear-address sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RST;
      busy_r  <= 1'b1;
`ifdef RAM_ARB_CLEAR_EN
      clr_addr_r <= '0;
`endif
    end else begin
      case (state_r)
        ST_RST: begin
`ifdef RAM_ARB_CLEAR_EN
          state_r    <= ST_CLEAR;
          clr_addr_r <= '0;
`else
          state_r <= ST_RUN;
          busy_r  <= 1'b0;
`endif
        end
        ST_CLEAR: begin
`ifdef RAM_ARB_CLEAR_EN
          clr_addr_r <= clr_addr_r + ADDR_WIDTH'(1);
          if (clr_addr_r == {ADDR_WIDTH{1'b1}}) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end
`else
          state_r <= ST_RUN;
          busy_r  <= 1'b0;
`endif
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_RST;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Arbitration pointer advances only on an actual transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= CH_W'(NUM_CH - 1);
    end else if (xfer_s) begin
      last_grant_r <= gidx_s;
    end
  end

  // Memory array: no reset so contents survive rst_n
  always_ff @(posedge clk) begin
`ifdef RAM_ARB_CLEAR_EN
    if (state_r == ST_CLEAR) begin
      mem_r[clr_addr_r] <= '0;
    end else
`endif
    if (xfer_s && sel_we_s) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (sel_be_s[b]) begin
          mem_r[sel_addr_s][8*b +: 8] <= sel_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Registered read responses; other channels keep their last data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
    end else begin
      rsp_valid_r <= '0;
      if (xfer_s && !sel_we_s) begin
        rsp_valid_r[gidx_s]                            <= 1'b1;
        rsp_rdata_r[gidx_s*DATA_WIDTH +: DATA_WIDTH]   <= mem_r[sel_addr_s];
      end
    end
  end

endmodule

// File: tb/tb_ram_arb_nport.sv
// Randomized bench for ram_arb_nport against an array-based memory/arbitration model.
// Expects RAM_ARB_CLEAR_EN to be defined the same way for bench and design.
module tb_ram_arb_nport;

  localparam int NC = 3;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     req_valid;
  logic [NC-1:0]     req_ready;
  logic [NC-1:0]     req_we;
  logic [NC*BW-1:0]  req_be;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*DW-1:0]  req_wdata;
  logic [NC-1:0]     rsp_valid;
  logic [NC*DW-1:0]  rsp_rdata;
  logic              busy;

  ram_arb_nport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mdl_mem [2**AW];
  logic [DW-1:0] exp_data [NC];
  logic [NC-1:0] exp_v;
  logic [NC-1:0] served;
  int            m_last;

`ifdef RAM_ARB_CLEAR_EN
  localparam int RUN_WAIT = 2**AW + 1;
`else
  localparam int RUN_WAIT = 1;
`endif

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First valid channel strictly after 'last', wrapping around
  function automatic int mdl_pick(input logic [NC-1:0] v, input int last);
    for (int k = 1; k <= NC; k++) begin
      if (v[(last + k) % NC]) return (last + k) % NC;
    end
    return -1;
  endfunction

  task automatic set_req(input int c, input logic v, input logic we, input logic [BW-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[c]         = v;
    req_we[c]            = we;
    req_be[c*BW +: BW]   = be;
    req_addr[c*AW +: AW] = a;
    req_wdata[c*DW +: DW] = d;
  endtask

  task automatic idle();
    for (int c = 0; c < NC; c++) set_req(c, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic model_reset();
    m_last = NC - 1;
    exp_v  = '0;
    served = '0;
    for (int c = 0; c < NC; c++) exp_data[c] = '0;
  endtask

  // Called at a negedge with inputs driven; returns at the next negedge
  task automatic step();
    int g;
    logic [NC-1:0] er;
    logic [AW-1:0] a;
    #1;
    g  = mdl_pick(req_valid, m_last);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check_val("ready", 128'(req_ready), 128'(er));
    exp_v = '0;
    if (g >= 0) begin
      m_last = g;
      a = req_addr[g*AW +: AW];
      if (req_we[g]) begin
        for (int b = 0; b < BW; b++)
          if (req_be[g*BW + b]) mdl_mem[a][8*b +: 8] = req_wdata[g*DW + 8*b +: 8];
      end else begin
        exp_v[g]    = 1'b1;
        exp_data[g] = mdl_mem[a];
      end
    end
    served = er;
    @(posedge clk);
    @(negedge clk);
    check_val("rsp_valid", 128'(rsp_valid), 128'(exp_v));
    for (int c = 0; c < NC; c++)
      check_val("rsp_rdata", 128'(rsp_rdata[c*DW +: DW]), 128'(exp_data[c]));
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check_val("busy_cycles", 128'(n), 128'(RUN_WAIT));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    req_valid = '1;
    model_reset();
    #23;
    check_val("rst_busy", 128'(busy), 128'(1));
    check_val("rst_ready", 128'(req_ready), 128'(0));
    check_val("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check_val("rst_rdata", 128'(rsp_rdata), 128'(0));
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    wait_run();
`ifdef RAM_ARB_CLEAR_EN
    for (int a = 0; a < 2**AW; a++) mdl_mem[a] = '0;
`endif

    // Fill every word so the model is fully defined
    for (int a = 0; a < 2**AW; a++) begin
      idle();
      set_req(0, 1'b1, 1'b1, 4'hF, AW'(a), $urandom);
      step();
    end

    // Single-channel byte write and read-back
    idle(); set_req(0, 1'b1, 1'b1, 4'h1, 6'h10, 32'h000000A5); step();
    idle(); set_req(0, 1'b1, 1'b0, 4'h0, 6'h10, 32'h0); step();
    check_val("a5_byte", 128'(rsp_rdata[7:0]), 128'(8'hA5));

    // Byte-lane merge on channel 2
    idle(); set_req(2, 1'b1, 1'b1, 4'hF, 6'h21, 32'h11223344); step();
    idle(); set_req(2, 1'b1, 1'b1, 4'h5, 6'h21, 32'hAABBCCDD); step();
    idle(); set_req(2, 1'b1, 1'b0, 4'h0, 6'h21, 32'h0); step();
    check_val("be_merge", 128'(rsp_rdata[2*DW +: DW]), 128'(32'h11BB33DD));

    // Late drop: ch1 loses to ch0, withdraws, then ch1 still wins over ch2
    idle(); set_req(0, 1'b1, 1'b0, 4'h0, 6'h05, 32'h0); set_req(1, 1'b1, 1'b0, 4'h0, 6'h06, 32'h0); step();
    idle(); step();
    set_req(1, 1'b1, 1'b0, 4'h0, 6'h07, 32'h0); set_req(2, 1'b1, 1'b0, 4'h0, 6'h08, 32'h0);
    #1;
    check_val("after_drop", 128'(req_ready), 128'(3'b010));
    step();

    // Random traffic with holds and occasional withdrawals
    idle(); served = '0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        if (req_valid[c] && !served[c]) begin
          if ($urandom_range(7) == 0) req_valid[c] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          set_req(c, 1'b1, 1'($urandom_range(1)), 4'($urandom), 6'($urandom), $urandom);
        end else begin
          req_valid[c] = 1'b0;
        end
      end
      step();
    end

    // Reset arriving right after a read handshake
    idle(); set_req(0, 1'b1, 1'b0, 4'h0, 6'h10, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check_val("mid_rst_busy", 128'(busy), 128'(1));
    check_val("mid_rst_ready", 128'(req_ready), 128'(0));
    model_reset();
    @(negedge clk); @(negedge clk);
    check_val("mid_rst_rdata", 128'(rsp_rdata), 128'(0));
    idle();
    rst_n = 1'b1;
    wait_run();
`ifdef RAM_ARB_CLEAR_EN
    for (int a = 0; a < 2**AW; a++) mdl_mem[a] = '0;
`endif
    idle(); set_req(0, 1'b1, 1'b0, 4'h0, 6'h10, 32'h0); step();

    // Round robin with all channels continuously reading, starting from reset pointer
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_run();
`ifdef RAM_ARB_CLEAR_EN
    for (int a = 0; a < 2**AW; a++) mdl_mem[a] = '0;
`endif
    for (int c = 0; c < NC; c++) set_req(c, 1'b1, 1'b0, 4'h0, AW'(c + 1), 32'h0);
    #1;
    check_val("first_grant", 128'(req_ready), 128'(3'b001));
    for (int i = 0; i < 3 * NC; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
